// File: rtl/aes_pkg.sv
// Shared AES definitions: key width, round constants and the key-schedule FSM states.
package aes_pkg;

  localparam int unsigned AES_KEY_W  = 128;
  localparam int unsigned AES_WORD_W = 32;
  localparam int unsigned AES_RND_W  = 4;
  localparam logic [AES_RND_W-1:0] AES_LAST_RND = AES_RND_W'(10);

  // Indexed by the round whose key is being inverted; entries 0 and 11..15 are never used.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } ks_state_e;

  function automatic logic [AES_WORD_W-1:0] rot_word(input logic [AES_WORD_W-1:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_inv_key_schedule_if.sv
// Load request and round-key stream between the inverse key schedule and its users.
interface aes_inv_key_schedule_if #(
  parameter int unsigned WIDTH = 128
);
  logic             start_i;
  logic [WIDTH-1:0] key_i;
  logic             busy_o;
  logic             key_valid_o;
  logic             key_ready_i;
  logic [WIDTH-1:0] key_o;
  logic [3:0]       round_o;
  logic             last_o;

  modport master (
    output start_i, key_i, key_ready_i,
    input  busy_o, key_valid_o, key_o, round_o, last_o
  );

  modport slave (
    input  start_i, key_i, key_ready_i,
    output busy_o, key_valid_o, key_o, round_o, last_o
  );
endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box, purely combinational table lookup.
module aes_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign data_o = SBOX[data_i];

endmodule

// File: rtl/aes_inv_key_schedule.sv
// Iterative inverse AES-128 key schedule: loads the round-10 key and streams keys 10..0
// over a valid/ready handshake, deriving each earlier key on the fly.
module aes_inv_key_schedule
  import aes_pkg::*;
(
  input  logic                         clk_i,
  input  logic                         rst_i,
  aes_inv_key_schedule_if.slave        ks
);

  ks_state_e              state_q, state_d;
  logic [AES_KEY_W-1:0]   key_q, key_d;
  logic [AES_RND_W-1:0]   rnd_q, rnd_d;

  logic [AES_WORD_W-1:0]  w0, w1, w2, w3;
  logic [AES_WORD_W-1:0]  p0, p1, p2, p3;
  logic [AES_WORD_W-1:0]  rot_p3, sub_p3;
  logic [AES_KEY_W-1:0]   prev_key;

  // Inverse expansion step: recover key r-1 from key r held in key_q.
  assign {w0, w1, w2, w3} = key_q;
  assign p3     = w3 ^ w2;
  assign p2     = w2 ^ w1;
  assign p1     = w1 ^ w0;
  assign rot_p3 = rot_word(p3);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .data_i (rot_p3[8*b +: 8]),
      .data_o (sub_p3[8*b +: 8])
    );
  end

  assign p0       = w0 ^ sub_p3 ^ {RCON[rnd_q], 24'h0};
  assign prev_key = {p0, p1, p2, p3};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      key_q   <= '0;
      rnd_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rnd_d   = rnd_q;
    unique case (state_q)
      IDLE: begin
        if (ks.start_i) begin
          key_d   = ks.key_i;
          rnd_d   = AES_LAST_RND;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (ks.key_ready_i) begin
          if (rnd_q != '0) begin
            key_d = prev_key;
            rnd_d = AES_RND_W'(rnd_q - AES_RND_W'(1));
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are pure decodes of the state registers.
  assign ks.busy_o      = (state_q == EMIT);
  assign ks.key_valid_o = (state_q == EMIT);
  assign ks.key_o       = key_q;
  assign ks.round_o     = rnd_q;
  assign ks.last_o      = (state_q == EMIT) && (rnd_q == '0);

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Directed and scoreboard bench for the inverse AES-128 key schedule.
module tb_aes_inv_key_schedule;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  aes_inv_key_schedule_if #(.WIDTH(128)) ks ();

  aes_inv_key_schedule dut (
    .clk_i (clk),
    .rst_i (rst),
    .ks    (ks)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K9   = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] K1   = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] K0   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KALT = 128'h00112233445566778899aabbccddeeff;

  logic [7:0]   m_sbox [256];
  logic [7:0]   m_rcon [11];
  logic [127:0] exp_key [11];

  // Reference S-box built from GF(2^8) inversion plus the affine map.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [127:0] inv_step(input logic [127:0] k, input int r);
    logic [31:0] w0, w1, w2, w3, p0, p1, p2, p3, rw, sw;
    {w0, w1, w2, w3} = k;
    p3 = w3 ^ w2;
    p2 = w2 ^ w1;
    p1 = w1 ^ w0;
    rw = {p3[23:0], p3[31:24]};
    sw = {m_sbox[rw[31:24]], m_sbox[rw[23:16]], m_sbox[rw[15:8]], m_sbox[rw[7:0]]};
    p0 = w0 ^ sw ^ {m_rcon[r], 24'h0};
    return {p0, p1, p2, p3};
  endfunction

  task automatic build_model();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      m_sbox[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    m_rcon[0] = 8'h00;
    m_rcon[1] = 8'h01;
    for (int i = 2; i < 11; i++) m_rcon[i] = xt(m_rcon[i-1]);
  endtask

  task automatic fill_expected(input logic [127:0] k10);
    exp_key[10] = k10;
    for (int r = 10; r >= 1; r--) exp_key[r-1] = inv_step(exp_key[r], r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    ks.start_i = 1'b0;
    ks.key_i = '0;
    ks.key_ready_i = 1'b0;
    tick();
    tick();
    tests++; if (ks.busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", ks.busy_o); end
    tests++; if (ks.key_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", ks.key_valid_o); end
    tests++; if (ks.last_o !== 1'b0) begin fails++; $display("FAIL reset_last got %b want 0", ks.last_o); end
    tests++; if (ks.key_o !== 128'h0) begin fails++; $display("FAIL reset_key got %h want 0", ks.key_o); end
    tests++; if (ks.round_o !== 4'd0) begin fails++; $display("FAIL reset_round got %0d want 0", ks.round_o); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fips();
    fill_expected(K10);
    ks.key_ready_i = 1'b1;
    ks.key_i = K10;
    ks.start_i = 1'b1;
    tick();
    ks.start_i = 1'b0;
    for (int r = 10; r >= 0; r--) begin
      tests++; if (ks.key_valid_o !== 1'b1 || ks.round_o !== 4'(r)) begin
        fails++; $display("FAIL fips_round got v=%b r=%0d want v=1 r=%0d", ks.key_valid_o, ks.round_o, r); end
      tests++; if (ks.last_o !== (r == 0)) begin
        fails++; $display("FAIL fips_last r=%0d got %b want %b", r, ks.last_o, r == 0); end
      if (r == 10) begin
        tests++; if (ks.key_o !== K10) begin fails++; $display("FAIL fips_k10 got %h want %h", ks.key_o, K10); end
      end
      if (r == 9) begin
        tests++; if (ks.key_o !== K9) begin fails++; $display("FAIL fips_k9 got %h want %h", ks.key_o, K9); end
      end
      if (r == 1) begin
        tests++; if (ks.key_o !== K1) begin fails++; $display("FAIL fips_k1 got %h want %h", ks.key_o, K1); end
      end
      if (r == 0) begin
        tests++; if (ks.key_o !== K0) begin fails++; $display("FAIL fips_k0 got %h want %h", ks.key_o, K0); end
      end
      tick();
    end
    tests++; if (ks.busy_o !== 1'b0 || ks.key_valid_o !== 1'b0) begin
      fails++; $display("FAIL fips_done got busy=%b valid=%b want 0 0", ks.busy_o, ks.key_valid_o); end
    tests++; if (ks.key_o !== K0) begin fails++; $display("FAIL fips_hold got %h want %h", ks.key_o, K0); end
  endtask

  task automatic test_backpressure();
    int  e = 10;
    bit  done = 1'b0;
    bit  rdy;
    int  cyc = 0;
    fill_expected(K10);
    ks.key_ready_i = 1'b0;
    ks.key_i = K10;
    ks.start_i = 1'b1;
    tick();
    ks.start_i = 1'b0;
    while (!done && cyc < 300) begin
      tests++; if (ks.key_valid_o !== 1'b1 || ks.round_o !== 4'(e) || ks.key_o !== exp_key[e]) begin
        fails++; $display("FAIL bp_beat got v=%b r=%0d k=%h want v=1 r=%0d k=%h",
                          ks.key_valid_o, ks.round_o, ks.key_o, e, exp_key[e]); end
      rdy = 1'($urandom_range(0, 1));
      ks.key_ready_i = rdy;
      tick();
      cyc++;
      if (rdy) begin
        if (e == 0) done = 1'b1;
        else e--;
      end
    end
    tests++; if (!done) begin fails++; $display("FAIL bp_timeout got round %0d want completion", e); end
    tests++; if (ks.busy_o !== 1'b0) begin fails++; $display("FAIL bp_idle got busy=%b want 0", ks.busy_o); end
  endtask

  task automatic test_start_ignored();
    fill_expected(K10);
    ks.key_ready_i = 1'b1;
    ks.key_i = K10;
    ks.start_i = 1'b1;
    tick();
    ks.start_i = 1'b0;
    for (int r = 10; r >= 0; r--) begin
      if (r == 7) begin
        ks.start_i = 1'b1;
        ks.key_i = KALT;
      end else begin
        ks.start_i = 1'b0;
      end
      tests++; if (ks.round_o !== 4'(r) || ks.key_o !== exp_key[r]) begin
        fails++; $display("FAIL ign_beat got r=%0d k=%h want r=%0d k=%h", ks.round_o, ks.key_o, r, exp_key[r]); end
      tick();
    end
    ks.start_i = 1'b0;
    tests++; if (ks.busy_o !== 1'b0) begin fails++; $display("FAIL ign_idle got busy=%b want 0", ks.busy_o); end
  endtask

  task automatic test_reset_mid();
    fill_expected(K10);
    ks.key_ready_i = 1'b1;
    ks.key_i = K10;
    ks.start_i = 1'b1;
    tick();
    ks.start_i = 1'b0;
    repeat (5) tick();
    tests++; if (ks.round_o !== 4'd5) begin fails++; $display("FAIL rst_pre got r=%0d want 5", ks.round_o); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++; if (ks.busy_o !== 1'b0 || ks.key_valid_o !== 1'b0 || ks.last_o !== 1'b0 ||
                 ks.key_o !== 128'h0 || ks.round_o !== 4'd0) begin
      fails++; $display("FAIL rst_mid got b=%b v=%b l=%b k=%h r=%0d want all 0",
                        ks.busy_o, ks.key_valid_o, ks.last_o, ks.key_o, ks.round_o); end
    tick();
    tests++; if (ks.busy_o !== 1'b0) begin fails++; $display("FAIL rst_idle got busy=%b want 0", ks.busy_o); end
    ks.start_i = 1'b1;
    tick();
    ks.start_i = 1'b0;
    tests++; if (ks.round_o !== 4'd10 || ks.key_o !== K10) begin
      fails++; $display("FAIL rst_restart got r=%0d k=%h want r=10 k=%h", ks.round_o, ks.key_o, K10); end
    repeat (10) tick();
    tests++; if (ks.last_o !== 1'b1 || ks.key_o !== K0) begin
      fails++; $display("FAIL rst_final got l=%b k=%h want l=1 k=%h", ks.last_o, ks.key_o, K0); end
    tick();
  endtask

  task automatic test_back_to_back();
    ks.key_ready_i = 1'b1;
    ks.key_i = K10;
    ks.start_i = 1'b1;
    tick();
    for (int r = 10; r >= 0; r--) begin
      tests++; if (ks.round_o !== 4'(r) || ks.key_valid_o !== 1'b1) begin
        fails++; $display("FAIL b2b_beat got v=%b r=%0d want v=1 r=%0d", ks.key_valid_o, ks.round_o, r); end
      tick();
    end
    tests++; if (ks.busy_o !== 1'b0 || ks.key_valid_o !== 1'b0) begin
      fails++; $display("FAIL b2b_gap got busy=%b valid=%b want 0 0", ks.busy_o, ks.key_valid_o); end
    tick();
    ks.start_i = 1'b0;
    tests++; if (ks.key_valid_o !== 1'b1 || ks.round_o !== 4'd10 || ks.key_o !== K10) begin
      fails++; $display("FAIL b2b_reload got v=%b r=%0d k=%h want v=1 r=10 k=%h",
                        ks.key_valid_o, ks.round_o, ks.key_o, K10); end
    repeat (11) tick();
    tests++; if (ks.busy_o !== 1'b0) begin fails++; $display("FAIL b2b_drain got busy=%b want 0", ks.busy_o); end
  endtask

  task automatic test_scoreboard();
    logic [127:0] k10;
    int           cyc;
    ks.key_ready_i = 1'b1;
    for (int n = 0; n <= 1000; n++) begin
      k10 = (n == 0) ? 128'h0 : {$urandom, $urandom, $urandom, $urandom};
      fill_expected(k10);
      ks.key_i = k10;
      ks.start_i = 1'b1;
      tick();
      ks.start_i = 1'b0;
      cyc = 0;
      while (!(ks.key_valid_o === 1'b1 && ks.last_o === 1'b1) && cyc < 20) begin
        tick();
        cyc++;
      end
      tests++; if (ks.last_o !== 1'b1 || ks.key_o !== exp_key[0]) begin
        fails++; $display("FAIL sb_key%0d in=%h got l=%b k=%h want l=1 k=%h",
                          n, k10, ks.last_o, ks.key_o, exp_key[0]); end
      tick();
    end
  endtask

  initial begin
    build_model();
    test_reset();
    test_fips();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    test_scoreboard();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
